// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit channel between NUM_REQ byte
// sources, with grants held for a whole message or MAX_BURST bytes.
//
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   req_data/valid/last per-requester byte, valid and end-of-message flags
//   req_ready          per-requester accept, high only for the granted source in LOAD
//   tx_data/tx_valid   registered byte and valid toward uart_top
//   tx_ready           uart_top accept; transfer on tx_valid & tx_ready
//   grant_id           index of the current or most recently granted requester
//   busy               high whenever the arbiter is not idle
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned ID_W      = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [ID_W-1:0]      grant_id,
    output logic                 busy
);

    localparam int unsigned BC_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             last_q;
    logic [BC_W-1:0]  burst_cnt;
    logic             rr_found;
    logic [ID_W-1:0]  rr_pick;
    logic [ID_W-1:0]  rr_idx;
    logic             grant_done;
    logic [7:0]       grant_byte;

    // Message ends on an explicit last byte or when the burst cap is reached.
    assign grant_done = last_q || (burst_cnt == BC_W'(MAX_BURST));
    assign grant_byte = req_data[{grant_id, 3'b000} +: 8];

    // Round-robin search: first valid requester after grant_id, with wrap.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = grant_id;
        rr_idx   = grant_id;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            rr_idx = ID_W'((32'(grant_id) + i) % NUM_REQ);
            if (!rr_found && req_valid[rr_idx]) begin
                rr_found = 1'b1;
                rr_pick  = rr_idx;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (rr_found) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (req_valid[grant_id]) begin
                    state_nxt = ST_SEND;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (tx_ready) begin
                    state_nxt = grant_done ? ST_IDLE : ST_LOAD;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        req_ready = '0;
        busy      = (state != ST_IDLE);
        if (state == ST_LOAD) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // Grant pointer, captured byte and burst accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_id  <= ID_W'(NUM_REQ - 1);
            tx_data   <= 8'h00;
            tx_valid  <= 1'b0;
            last_q    <= 1'b0;
            burst_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rr_found) begin
                        grant_id <= rr_pick;
                    end
                end
                ST_LOAD: begin
                    if (req_valid[grant_id]) begin
                        tx_data   <= grant_byte;
                        last_q    <= req_last[grant_id];
                        burst_cnt <= burst_cnt + BC_W'(1);
                        tx_valid  <= 1'b1;
                    end else begin
                        // Source stalled mid-message: give up the grant, keep the pointer.
                        burst_cnt <= '0;
                    end
                end
                ST_SEND: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        if (grant_done) begin
                            burst_cnt <= '0;
                        end
                    end
                end
                default: begin
                    tx_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queued byte sources, a message-level round-robin
// model producing the expected transmit order, directed and random scenarios.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR*8-1:0] req_data;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ready;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready;
    logic [1:0]      grant_id;
    logic            busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_data  (req_data),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    // Source byte stores: {last, data} per entry.
    logic [8:0]  src_mem [NR][64];
    int          src_rd [NR];
    int          src_wr [NR];
    byte unsigned exp_q[$];
    int          model_ptr;
    int          chk_grant;
    int          n_xfer;
    bit          rand_ready;
    int          total;
    int          bad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_srcs();
        for (int k = 0; k < NR; k++) begin
            src_rd[k] = 0;
            src_wr[k] = 0;
        end
    endtask

    task automatic push_byte(input int k, input logic [7:0] d, input logic l);
        src_mem[k][src_wr[k]] = {l, d};
        src_wr[k]++;
    endtask

    task automatic drive_srcs();
        for (int k = 0; k < NR; k++) begin
            if (src_rd[k] < src_wr[k]) begin
                req_valid[k]         = 1'b1;
                req_last[k]          = src_mem[k][src_rd[k]][8];
                req_data[k*8 +: 8]   = src_mem[k][src_rd[k]][7:0];
            end else begin
                req_valid[k]         = 1'b0;
                req_last[k]          = 1'($urandom_range(0, 1));
                req_data[k*8 +: 8]   = 8'($urandom);
            end
        end
    endtask

    function automatic bit srcs_empty();
        bit e = 1'b1;
        for (int k = 0; k < NR; k++) begin
            if (src_rd[k] < src_wr[k]) e = 1'b0;
        end
        return e;
    endfunction

    // Message-level model: pick next non-empty source after the pointer,
    // take bytes until last, burst cap or the source runs dry.
    task automatic model_build();
        int rd [NR];
        int p;
        int k;
        int n;
        logic [8:0] v;
        for (int i = 0; i < NR; i++) rd[i] = src_rd[i];
        p = model_ptr;
        forever begin
            k = -1;
            for (int i = 1; i <= NR; i++) begin
                if (k < 0 && rd[(p + i) % NR] < src_wr[(p + i) % NR]) k = (p + i) % NR;
            end
            if (k < 0) break;
            p = k;
            n = 0;
            while (rd[k] < src_wr[k]) begin
                v = src_mem[k][rd[k]];
                rd[k]++;
                exp_q.push_back(v[7:0]);
                n++;
                if (v[8] || n == MB) break;
            end
        end
        model_ptr = p;
    endtask

    // One clock: sample handshakes at negedge, update inputs just after posedge.
    task automatic tick();
        logic [NR-1:0] acc;
        logic          xfer;
        byte unsigned  e;
        @(negedge clk);
        acc  = req_valid & req_ready;
        xfer = tx_valid & tx_ready;
        if (xfer) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL extra_byte observed=%0h expected=none", tx_data);
            end else begin
                e = exp_q.pop_front();
                check("tx_byte", 32'(tx_data), 32'(e));
                if (chk_grant >= 0) check("grant_during_msg", 32'(grant_id), 32'(chk_grant));
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < NR; k++) begin
            if (acc[k]) src_rd[k]++;
        end
        if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
        drive_srcs();
    endtask

    task automatic run_until_done(input int budget);
        int c = 0;
        while (!(exp_q.size() == 0 && srcs_empty() && !busy && !tx_valid) && c < budget) begin
            tick();
            c++;
        end
        total++;
        if (c >= budget) begin
            bad++;
            $error("FAIL timeout observed=%0d pending=%0d expected=0", c, exp_q.size());
        end
        check("idle_busy", 32'(busy), 32'd0);
        check("final_grant", 32'(grant_id), 32'(model_ptr));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_ptr = NR - 1;
        exp_q.delete();
    endtask

    initial begin
        int c;
        int nx0;
        total      = 0;
        bad        = 0;
        chk_grant  = -1;
        n_xfer     = 0;
        rand_ready = 1'b0;
        tx_ready   = 1'b1;
        req_valid  = '0;
        req_last   = '0;
        req_data   = '0;
        clear_srcs();
        rst = 1'b1;
        tick();
        tick();
        // Reset state.
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_grant", 32'(grant_id), 32'(NR - 1));
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        model_ptr = NR - 1;

        // Single source, three-byte message on requester 2.
        clear_srcs();
        push_byte(2, 8'h41, 1'b0);
        push_byte(2, 8'h42, 1'b0);
        push_byte(2, 8'h43, 1'b1);
        model_build();
        chk_grant = 2;
        run_until_done(200);
        chk_grant = -1;

        // Round-robin from a fresh pointer, twice.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            clear_srcs();
            push_byte(0, 8'hA0, 1'b1);
            push_byte(1, 8'hB1, 1'b1);
            push_byte(3, 8'hD3, 1'b1);
            model_build();
            check("rr_first", 32'(exp_q[0]), 32'hA0);
            run_until_done(200);
        end

        // Burst cap: bring pointer to 0 first, then long message vs short one.
        clear_srcs();
        push_byte(0, 8'h01, 1'b1);
        model_build();
        run_until_done(100);
        clear_srcs();
        for (int i = 0; i < 10; i++) push_byte(1, 8'(i), 1'b0);
        push_byte(0, 8'hEE, 1'b1);
        model_build();
        check("burst_5th", 32'(exp_q[4]), 32'hEE);
        run_until_done(400);

        // Random messages with random backpressure.
        rand_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            clear_srcs();
            for (int k = 0; k < NR; k++) begin
                int nm = $urandom_range(0, 2);
                for (int m = 0; m < nm; m++) begin
                    int len = $urandom_range(1, 6);
                    for (int b = 0; b < len; b++) push_byte(k, 8'($urandom), 1'(b == len - 1));
                end
            end
            model_build();
            run_until_done(2000);
        end
        rand_ready = 1'b0;

        // Backpressure: tx_ready low for 50 cycles.
        tx_ready = 1'b0;
        clear_srcs();
        push_byte(2, 8'h5A, 1'b1);
        model_build();
        c = 0;
        while (!tx_valid && c < 10) begin
            tick();
            c++;
        end
        check("bp_valid_rise", 32'(tx_valid), 32'd1);
        for (int i = 0; i < 50; i++) begin
            tick();
            check("bp_data", 32'(tx_data), 32'h5A);
            check("bp_valid", 32'(tx_valid), 32'd1);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        tx_ready = 1'b1;
        nx0 = n_xfer;
        for (int i = 0; i < 10; i++) tick();
        check("bp_one_xfer", 32'(n_xfer - nx0), 32'd1);
        run_until_done(50);

        // Stall release: requester 0 stops mid-message, requester 1 follows.
        clear_srcs();
        push_byte(0, 8'h11, 1'b0);
        push_byte(1, 8'h22, 1'b1);
        model_build();
        check("stall_order", 32'({exp_q[0], exp_q[1]}), 32'h1122);
        run_until_done(200);

        // Reset while holding a byte in SEND.
        tx_ready = 1'b0;
        clear_srcs();
        push_byte(2, 8'h99, 1'b1);
        model_build();
        c = 0;
        while (!tx_valid && c < 10) begin
            tick();
            c++;
        end
        check("mid_valid", 32'(tx_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_grant", 32'(grant_id), 32'(NR - 1));
        exp_q.delete();
        model_ptr = NR - 1;
        tx_ready = 1'b1;
        clear_srcs();
        push_byte(1, 8'h88, 1'b1);
        push_byte(0, 8'h77, 1'b1);
        model_build();
        check("post_rst_first", 32'(exp_q[0]), 32'h77);
        run_until_done(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit channel (tx_data/tx_valid/tx_ready of uart_top) between NUM_REQ independent byte sources.
- Round-robin arbitration at message granularity: a granted requester keeps the channel until it presents its last byte or hits MAX_BURST bytes, then the grant rotates.
- Sits between the system's byte producers (status, debug, command-response) and uart_top.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BURST, 16, maximum bytes per grant before forced rotation (>=1).
- ID_W, $clog2(NUM_REQ), width of the grant index (derived; not overridden).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- req_data  input  NUM_REQ*8  byte from requester k on bits [8k+7:8k].
- req_valid  input  NUM_REQ  requester k has a byte.
- req_last  input  NUM_REQ  byte on requester k ends its message.
- req_ready  output  NUM_REQ  requester k byte accepted this cycle (valid&ready).
- tx_data  output  8  byte to uart_top, registered.
- tx_valid  output  1  to uart_top, registered.
- tx_ready  input  1  from uart_top; a transfer occurs on tx_valid&tx_ready.
- grant_id  output  ID_W  index of the current or last granted requester.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: state=IDLE; tx_valid=0; tx_data=0; req_ready=0; grant_id=NUM_REQ-1, so requester 0 has first priority; burst_cnt=0; busy=0.
- States: IDLE, LOAD, SEND.
- IDLE:
  - If any req_valid, choose the first set bit searching from grant_id+1 upward with wrap.
  - Register that index into grant_id and go to LOAD next cycle.
  - Otherwise stay in IDLE.
- LOAD:
  - req_ready[grant_id] is driven combinationally high for exactly this state. All other req_ready bits are 0.
  - If req_valid[grant_id]=1: capture the byte into tx_data, capture req_last into last_q, increment burst_cnt, set tx_valid=1, go to SEND.
  - If req_valid[grant_id]=0 (source stalled mid-message): release the grant, clear burst_cnt, go to IDLE. The pointer stays at grant_id, so the next search starts at the following requester.
- SEND:
  - Hold tx_data and tx_valid stable until tx_ready=1.
  - On the transfer cycle, clear tx_valid next cycle.
  - If last_q=1 or burst_cnt==MAX_BURST: clear burst_cnt and go to IDLE.
  - Otherwise go to LOAD with the same grant.
- Latency:
  - req_valid rising in IDLE at cycle N gives req_ready at N+1 and tx_valid at N+2.
  - Back-to-back bytes in a burst: 2 cycles of overhead plus the UART busy time.
- Fairness: no requester is granted twice while another requester holds valid continuously through an IDLE search.
- Simultaneous requests: the lowest index above the pointer (with wrap) wins. The others stay pending; they are not dropped.
- tx_ready stuck low: the block stays in SEND indefinitely. There is no timeout.
- burst_cnt is $clog2(MAX_BURST+1) bits and never exceeds MAX_BURST.
- Reset mid-SEND: tx_valid drops the cycle after rst is sampled. The in-flight byte is abandoned; the requester has already been acked.
- req_data and req_last of non-granted requesters are ignored.

Test Plan:
- Single source: reset, then requester 2 sends 0x41,0x42,0x43 with last on 0x43 -> uart_top loopback rx_data shows 0x41,0x42,0x43 in order. grant_id=2 throughout. busy returns to 0 after the third transfer.
- Round-robin: requesters 0,1,3 all valid, each a 1-byte message (0xA0,0xB1,0xD3, last=1), asserted at once -> transmit order 0xA0,0xB1,0xD3. Repeating the stimulus gives the same order again, because the pointer is now at 3 and wraps to 0.
- Burst cap: MAX_BURST=4; requester 1 presents 10 bytes 0x00..0x09 and never asserts last; requester 0 presents 0xEE, last=1 -> UART sees 0x00..0x03, 0xEE, 0x04..0x07, then 0x08,0x09.
- Backpressure: hold tx_ready=0 for 50 cycles after tx_valid rises with 0x5A -> tx_data stays 0x5A and tx_valid stays 1. req_ready stays 0 for all requesters. Exactly one transfer occurs after tx_ready rises.
- Stall release: requester 0 sends 0x11 (last=0), then drops valid; requester 1 has 0x22 valid -> after 0x11, LOAD sees no valid from requester 0, goes to IDLE, and 0x22 is sent next.
- Reset mid-operation: assert rst for 1 cycle while in SEND with tx_ready=0 -> the next cycle shows tx_valid=0, busy=0, grant_id=NUM_REQ-1. A following request from requester 0 is granted first.
